// File: rtl/sad_argmin.sv
// Streaming arg-min over NUM_CAND costs per pixel: reports the minimum cost, its
// candidate index and the second-min minus min margin, behind a valid/ready output.
module sad_argmin #(
  parameter int WIDTH    = 16,
  parameter int NUM_CAND = 64,
  parameter bit SIGNED   = 1'b0,
  parameter bit TIE_LOW  = 1'b1,
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] cost_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] min_cost_out,
  output logic [IDX_W-1:0] min_idx_out,
  output logic [WIDTH:0]   margin_out
);

  localparam logic [WIDTH-1:0] SENT = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);

  function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
    if (SIGNED) return {v[WIDTH-1], v};
    else        return {1'b0, v};
  endfunction

  logic             accept;
  logic             last;
  logic             take;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [WIDTH-1:0] best;
  logic [WIDTH-1:0] second;
  logic [WIDTH-1:0] best_nxt;
  logic [WIDTH-1:0] second_nxt;
  logic [WIDTH:0]   margin_nxt;

  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out & ~flush_in;
  assign last      = (cnt == LAST);

  // Running best/second after folding in the current beat; the last beat's
  // result feeds the output registers directly so it is included in the answer.
  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = idx;
    take       = TIE_LOW ? less(cost_in, best) : ~less(best, cost_in);
    if (cnt == '0) begin
      best_nxt   = cost_in;
      second_nxt = SENT;
      idx_nxt    = '0;
    end else if (take) begin
      second_nxt = best;
      best_nxt   = cost_in;
      idx_nxt    = cnt;
    end else if (less(cost_in, second)) begin
      second_nxt = cost_in;
    end
    margin_nxt = ext(second_nxt) - ext(best_nxt);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt          <= '0;
      best         <= '0;
      second       <= '0;
      idx          <= '0;
      valid_out    <= 1'b0;
      min_cost_out <= '0;
      min_idx_out  <= '0;
      margin_out   <= '0;
    end else begin
      if (flush_in) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= last ? '0 : cnt + 1'b1;
        best   <= best_nxt;
        second <= second_nxt;
        idx    <= idx_nxt;
      end
      if (accept && last) begin
        valid_out    <= 1'b1;
        min_cost_out <= best_nxt;
        min_idx_out  <= idx_nxt;
        margin_out   <= margin_nxt;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_argmin.sv
// Bench for sad_argmin: three 4-candidate instances (unsigned tie-low, unsigned
// tie-high, 5-bit signed) checked against a queue of independently modelled results.
module tb_sad_argmin;

  typedef struct {
    int mn;
    int ix;
    int mg;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       f0, v0, r0, rdy0, vo0;
  logic [7:0] c0, mc0;
  logic [1:0] mi0;
  logic [8:0] mg0;
  logic       f1, v1, r1, rdy1, vo1;
  logic [7:0] c1, mc1;
  logic [1:0] mi1;
  logic [8:0] mg1;
  logic       f2, v2, r2, rdy2, vo2;
  logic [4:0] c2, mc2;
  logic [1:0] mi2;
  logic [5:0] mg2;

  int n_cmp = 0;
  int n_bad = 0;
  res_t q0[$], q1[$], q2[$];
  res_t e0, e1, e2;

  sad_argmin #(.WIDTH(8), .NUM_CAND(4), .SIGNED(1'b0), .TIE_LOW(1'b1)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(f0), .valid_in(v0), .ready_out(rdy0),
    .cost_in(c0), .valid_out(vo0), .ready_in(r0), .min_cost_out(mc0),
    .min_idx_out(mi0), .margin_out(mg0));

  sad_argmin #(.WIDTH(8), .NUM_CAND(4), .SIGNED(1'b0), .TIE_LOW(1'b0)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(f1), .valid_in(v1), .ready_out(rdy1),
    .cost_in(c1), .valid_out(vo1), .ready_in(r1), .min_cost_out(mc1),
    .min_idx_out(mi1), .margin_out(mg1));

  sad_argmin #(.WIDTH(5), .NUM_CAND(4), .SIGNED(1'b1), .TIE_LOW(1'b1)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(f2), .valid_in(v2), .ready_out(rdy2),
    .cost_in(c2), .valid_out(vo2), .ready_in(r2), .min_cost_out(mc2),
    .min_idx_out(mi2), .margin_out(mg2));

  // Minimum first (scan with tie policy), then second-min over the remaining entries.
  function automatic res_t model(input int a, input int b, input int c, input int d,
                                 input bit tie_low);
    int   v[4];
    int   bi;
    int   s;
    res_t r;
    v  = '{a, b, c, d};
    bi = 0;
    for (int i = 1; i < 4; i++)
      if (v[i] < v[bi] || (!tie_low && v[i] == v[bi])) bi = i;
    s = 32'h3fff_ffff;
    for (int j = 0; j < 4; j++)
      if (j != bi && v[j] < s) s = v[j];
    r.mn = v[bi];
    r.ix = bi;
    r.mg = s - v[bi];
    return r;
  endfunction

  function automatic logic rdy(input int which);
    case (which)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  // Presents one beat from a negedge and returns on the edge that accepts it.
  task automatic send(input int which, input int cost);
    int waits;
    waits = 0;
    @(negedge clk);
    case (which)
      0:       begin v0 = 1'b1; c0 = 8'(cost); end
      1:       begin v1 = 1'b1; c1 = 8'(cost); end
      default: begin v2 = 1'b1; c2 = 5'(cost); end
    endcase
    while (!rdy(which) && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout inst=%0d got ready_out=0 want ready_out=1", which);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int which);
    @(negedge clk);
    case (which)
      0:       v0 = 1'b0;
      1:       v1 = 1'b0;
      default: v2 = 1'b0;
    endcase
  endtask

  task automatic expect_res(input int which, input int a, input int b, input int c, input int d);
    res_t r;
    r = model(a, b, c, d, which != 1);
    case (which)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic stream(input int which, input int a, input int b, input int c, input int d,
                        input bit push);
    if (push) expect_res(which, a, b, c, d);
    send(which, a);
    send(which, b);
    send(which, c);
    send(which, d);
    idle(which);
  endtask

  always @(negedge clk) begin
    if (rst_n && vo0 && r0) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL u0_unexpected got min=%0d idx=%0d margin=%0d want no result", mc0, mi0, mg0);
      end else begin
        e0 = q0.pop_front();
        if ({mc0, mi0, mg0} !== {8'(e0.mn), 2'(e0.ix), 9'(e0.mg)}) begin
          n_bad++;
          $display("FAIL u0_result got min=%0d idx=%0d margin=%0d want min=%0d idx=%0d margin=%0d",
                   mc0, mi0, mg0, e0.mn, e0.ix, e0.mg);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vo1 && r1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL u1_unexpected got min=%0d idx=%0d margin=%0d want no result", mc1, mi1, mg1);
      end else begin
        e1 = q1.pop_front();
        if ({mc1, mi1, mg1} !== {8'(e1.mn), 2'(e1.ix), 9'(e1.mg)}) begin
          n_bad++;
          $display("FAIL u1_result got min=%0d idx=%0d margin=%0d want min=%0d idx=%0d margin=%0d",
                   mc1, mi1, mg1, e1.mn, e1.ix, e1.mg);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && vo2 && r2) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL u2_unexpected got min=%0d idx=%0d margin=%0d want no result",
                 $signed(mc2), mi2, mg2);
      end else begin
        e2 = q2.pop_front();
        if ({mc2, mi2, mg2} !== {5'(e2.mn), 2'(e2.ix), 6'(e2.mg)}) begin
          n_bad++;
          $display("FAIL u2_result got min=%0d idx=%0d margin=%0d want min=%0d idx=%0d margin=%0d",
                   $signed(mc2), mi2, mg2, e2.mn, e2.ix, e2.mg);
        end
      end
    end
  end

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({vo0, vo1, vo2} !== 3'b000 || {rdy0, rdy1, rdy2} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_handshake got valid=%b ready=%b want valid=000 ready=111",
               {vo0, vo1, vo2}, {rdy0, rdy1, rdy2});
    end
    n_cmp++;
    if ({mc0, mi0, mg0, mc1, mi1, mg1, mc2, mi2, mg2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got u0=%0d/%0d/%0d u1=%0d/%0d/%0d u2=%0d/%0d/%0d want all 0",
               mc0, mi0, mg0, mc1, mi1, mg1, mc2, mi2, mg2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_latency;
    expect_res(0, 9, 3, 7, 5);
    send(0, 9);
    send(0, 3);
    send(0, 7);
    #1;
    n_cmp++;
    if (vo0 !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_early got valid_out=%b want 0", vo0);
    end
    send(0, 5);
    #1;
    n_cmp++;
    if (vo0 !== 1'b1 || mc0 !== 8'd3 || mi0 !== 2'd1 || mg0 !== 9'd2) begin
      n_bad++;
      $display("FAIL latency_result got valid=%b min=%0d idx=%0d margin=%0d want valid=1 min=3 idx=1 margin=2",
               vo0, mc0, mi0, mg0);
    end
    idle(0);
  endtask

  task automatic test_ties;
    stream(0, 4, 2, 2, 8, 1'b1);
    stream(1, 4, 2, 2, 8, 1'b1);
    stream(0, 6, 6, 6, 6, 1'b1);
    stream(1, 6, 6, 6, 6, 1'b1);
  endtask

  task automatic test_signed;
    stream(2, -3, 4, -16, 15, 1'b1);
    stream(2, 15, 15, -16, -16, 1'b1);
    stream(2, -1, -2, 0, -2, 1'b1);
  endtask

  task automatic test_boundary;
    stream(0, 255, 255, 255, 255, 1'b1);
    stream(1, 0, 255, 0, 254, 1'b1);
    stream(2, 15, 15, 15, 15, 1'b1);
    stream(0, 255, 0, 255, 255, 1'b1);
  endtask

  task automatic test_backpressure;
    logic [7:0] hm;
    logic [1:0] hi;
    logic [8:0] hg;
    @(posedge clk);
    #1 r0 = 1'b0;
    stream(0, 9, 3, 7, 5, 1'b1);
    n_cmp++;
    if (vo0 !== 1'b1 || rdy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_stall got valid=%b ready_out=%b want valid=1 ready_out=0", vo0, rdy0);
    end
    hm = mc0;
    hi = mi0;
    hg = mg0;
    fork
      stream(0, 1, 2, 3, 0, 1'b1);
      begin
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({vo0, mc0, mi0, mg0} !== {1'b1, 8'd3, 2'd1, 9'd2} || {mc0, mi0, mg0} !== {hm, hi, hg}) begin
          n_bad++;
          $display("FAIL bp_hold got valid=%b min=%0d idx=%0d margin=%0d want valid=1 min=3 idx=1 margin=2",
                   vo0, mc0, mi0, mg0);
        end
        @(posedge clk);
        #1 r0 = 1'b1;
      end
    join
  endtask

  task automatic test_flush;
    send(0, 1);
    send(0, 1);
    @(negedge clk);
    f0 = 1'b1;
    v0 = 1'b1;
    c0 = 8'd0;
    @(negedge clk);
    f0 = 1'b0;
    v0 = 1'b0;
    stream(0, 6, 6, 1, 0, 1'b1);
    @(negedge clk);
    f0 = 1'b1;
    @(negedge clk);
    f0 = 1'b0;
    stream(0, 4, 9, 9, 2, 1'b1);
    @(posedge clk);
    #1 r0 = 1'b0;
    stream(0, 3, 1, 4, 1, 1'b1);
    @(negedge clk);
    f0 = 1'b1;
    @(negedge clk);
    f0 = 1'b0;
    n_cmp++;
    if (vo0 !== 1'b1 || mc0 !== 8'd1 || mi0 !== 2'd1) begin
      n_bad++;
      $display("FAIL flush_pending got valid=%b min=%0d idx=%0d want valid=1 min=1 idx=1", vo0, mc0, mi0);
    end
    @(posedge clk);
    #1 r0 = 1'b1;
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #1 r0 = 1'b0;
    stream(0, 8, 8, 8, 8, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vo0 !== 1'b0 || rdy0 !== 1'b1 || {mc0, mi0, mg0} !== '0) begin
      n_bad++;
      $display("FAIL areset_pending got valid=%b ready_out=%b min=%0d want valid=0 ready_out=1 min=0",
               vo0, rdy0, mc0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 r0 = 1'b1;
    send(0, 7);
    send(0, 7);
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vo0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_midstream got valid=%b ready_out=%b want valid=0 ready_out=1", vo0, rdy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stream(0, 5, 8, 2, 9, 1'b1);
  endtask

  task automatic test_back_to_back;
    int v[12];
    for (int i = 0; i < 12; i++) v[i] = int'($urandom_range(0, 9));
    for (int k = 0; k < 3; k++) expect_res(1, v[4*k], v[4*k+1], v[4*k+2], v[4*k+3]);
    for (int i = 0; i < 12; i++) send(1, v[i]);
    #1;
    n_cmp++;
    if (vo1 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_valid got valid_out=%b want 1", vo1);
    end
    idle(1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      stream(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
      stream(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1);
      stream(2, int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
             int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16, 1'b1);
    end
  endtask

  task automatic test_drain;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain got outstanding=%0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    {f0, v0, c0} = '0;
    {f1, v1, c1} = '0;
    {f2, v2, c2} = '0;
    r0 = 1'b1;
    r1 = 1'b1;
    r2 = 1'b1;
    test_reset();
    test_basic_latency();
    test_ties();
    test_signed();
    test_boundary();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
